// File: rtl/risc16_cpu_pkg.sv
// Shared definitions for the risc16 core: FSM state codes, opcode values and
// instruction field slicing helpers.
package risc16_cpu_pkg;

    typedef enum logic [4:0] {
        StIdle   = 5'd0,
        StFetch  = 5'd1,
        StDecode = 5'd2,
        StExec   = 5'd3,
        StMem    = 5'd4,
        StWb     = 5'd5,
        StHalt   = 5'd6
    } state_e;

    localparam logic [4:0] OpHalt = 5'b00000;
    localparam logic [4:0] OpLli  = 5'b00010;
    localparam logic [4:0] OpLdr  = 5'b00011;
    localparam logic [4:0] OpStr  = 5'b00101;
    localparam logic [4:0] OpAddi = 5'b00111;
    localparam logic [4:0] OpSubi = 5'b01000;
    localparam logic [4:0] OpBne  = 5'b11000;
    localparam logic [4:0] OpOut  = 5'b11100;

    function automatic logic [4:0] ir_op(input logic [15:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [2:0] ir_rd(input logic [15:0] ir);
        return ir[10:8];
    endfunction

    function automatic logic [2:0] ir_rs(input logic [15:0] ir);
        return ir[7:5];
    endfunction

    // imm5 and imm8 are zero-extended, the branch offset is sign-extended
    function automatic logic [15:0] ir_imm5(input logic [15:0] ir);
        return {11'h000, ir[4:0]};
    endfunction

    function automatic logic [15:0] ir_imm8(input logic [15:0] ir);
        return {8'h00, ir[7:0]};
    endfunction

    function automatic logic [15:0] ir_off8(input logic [15:0] ir);
        return {{8{ir[7]}}, ir[7:0]};
    endfunction

endpackage

// File: rtl/risc16_regfile.sv
// Eight 16-bit general registers.
// Ports: clk/rst_n (async active-low clear), we/waddr/wdata write port,
// raddr_a/rdata_a and raddr_b/rdata_b combinational read ports.
module risc16_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [2:0]  raddr_a,
    output logic [15:0] rdata_a,
    input  logic [2:0]  raddr_b,
    output logic [15:0] rdata_b
);

    logic [15:0] regs_q [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/risc16_cpu.sv
// Multicycle 16-bit load/store core with a unified 256x16 memory.
// Ports: clk, rst_n (async active-low, memory preserved); test port
// ext_addr/ext_data/test/tMemWrite/TestMem/TestMemout for loading and
// inspecting memory; start runs the core from IDLE; OutR is the OUT register,
// state the FSM code and opcode the instruction register.
module risc16_cpu
    import risc16_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ext_addr,
    input  logic [15:0] ext_data,
    input  logic        test,
    input  logic        tMemWrite,
    input  logic        TestMem,
    input  logic        start,
    output logic [15:0] OutR,
    output logic [4:0]  state,
    output logic [15:0] opcode,
    output logic [15:0] TestMemout
);

    logic [15:0] mem [256];

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] outr_q;
    logic [15:0] alu_q;   // ALU result, memory address, then load data

    logic [4:0]  op;
    logic [15:0] rs_val;
    logic [15:0] rd_val;
    logic        reg_we;
    logic        unused_ext_addr;

    assign op              = ir_op(ir_q);
    assign unused_ext_addr = ^ext_addr[15:8];

    // The core is frozen while the test port owns the machine.
    assign reg_we = (state_q == StWb) && !test;

    risc16_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (reg_we),
        .waddr   (ir_rd(ir_q)),
        .wdata   (alu_q),
        .raddr_a (ir_rs(ir_q)),
        .rdata_a (rs_val),
        .raddr_b (ir_rd(ir_q)),
        .rdata_b (rd_val)
    );

    // Memory has no reset so a program survives a core reset.
    always_ff @(posedge clk) begin
        if (test) begin
            if (tMemWrite) begin
                mem[ext_addr[7:0]] <= ext_data;
            end
        end else if (state_q == StMem && op == OpStr) begin
            mem[alu_q[7:0]] <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            outr_q  <= '0;
            alu_q   <= '0;
        end else if (test) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    ir_q    <= mem[pc_q[7:0]];
                    pc_q    <= pc_q + 16'd1;
                    state_q <= StDecode;
                end
                StDecode: begin
                    state_q <= (op == OpHalt) ? StHalt : StExec;
                end
                StExec: begin
                    case (op)
                        OpLli: begin
                            alu_q   <= ir_imm8(ir_q);
                            state_q <= StWb;
                        end
                        OpAddi: begin
                            alu_q   <= rs_val + ir_imm5(ir_q);
                            state_q <= StWb;
                        end
                        OpSubi: begin
                            alu_q   <= rs_val - ir_imm5(ir_q);
                            state_q <= StWb;
                        end
                        OpLdr, OpStr: begin
                            alu_q   <= rs_val + ir_imm5(ir_q);
                            state_q <= StMem;
                        end
                        OpBne: begin
                            // pc_q already points past the branch
                            if (rd_val != 16'h0000) begin
                                pc_q <= pc_q + ir_off8(ir_q);
                            end
                            state_q <= StFetch;
                        end
                        OpOut: begin
                            outr_q  <= rs_val;
                            state_q <= StFetch;
                        end
                        default: state_q <= StFetch;
                    endcase
                end
                StMem: begin
                    if (op == OpLdr) begin
                        alu_q   <= mem[alu_q[7:0]];
                        state_q <= StWb;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StWb:    state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign OutR       = outr_q;
    assign state      = state_q;
    assign opcode     = ir_q;
    assign TestMemout = TestMem ? mem[ext_addr[7:0]] : 16'h0000;

endmodule

// File: tb/tb_risc16_cpu.sv
module tb_risc16_cpu;

    localparam logic [4:0] OpcLli  = 5'b00010;
    localparam logic [4:0] OpcLdr  = 5'b00011;
    localparam logic [4:0] OpcStr  = 5'b00101;
    localparam logic [4:0] OpcAddi = 5'b00111;
    localparam logic [4:0] OpcSubi = 5'b01000;
    localparam logic [4:0] OpcBne  = 5'b11000;
    localparam logic [4:0] OpcOut  = 5'b11100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ext_addr;
    logic [15:0] ext_data;
    logic        test;
    logic        tMemWrite;
    logic        TestMem;
    logic        start;
    logic [15:0] OutR;
    logic [4:0]  state;
    logic [15:0] opcode;
    logic [15:0] TestMemout;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] img [256];   // image loaded through the test port
    logic [15:0] mm  [256];   // reference model memory
    logic [15:0] exp_outs [$];
    logic [15:0] got_outs [$];

    typedef struct {
        logic        wr;
        logic        tst;
        logic [15:0] addr;
        logic [15:0] data;
        logic        tmem;
        logic [15:0] exp;
    } tp_vec_t;

    tp_vec_t vecs [8];

    risc16_cpu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ext_addr   (ext_addr),
        .ext_data   (ext_data),
        .test       (test),
        .tMemWrite  (tMemWrite),
        .TestMem    (TestMem),
        .start      (start),
        .OutR       (OutR),
        .state      (state),
        .opcode     (opcode),
        .TestMemout (TestMemout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_read(input logic [15:0] addr, output logic [15:0] data);
        TestMem  = 1'b1;
        ext_addr = addr;
        #1;
        data = TestMemout;
    endtask

    task automatic load_img();
        test = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ext_addr  = 16'(i);
            ext_data  = img[i];
            tMemWrite = 1'b1;
            tick();
        end
        tMemWrite = 1'b0;
        test      = 1'b0;
    endtask

    // ISA-level reference: executes mm in place, collects OUT values and cycles
    task automatic model_run(output int cyc, output bit halted);
        logic [15:0] r [8];
        logic [15:0] pc, ir, a;
        logic [4:0]  op;
        logic [2:0]  rd, rs;
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        pc = 16'h0;
        cyc = 1;
        halted = 1'b0;
        exp_outs.delete();
        for (int n = 0; n < 200; n++) begin
            ir = mm[pc[7:0]];
            pc = pc + 16'd1;
            op = ir[15:11];
            rd = ir[10:8];
            rs = ir[7:5];
            a  = r[rs] + {11'h0, ir[4:0]};
            if (op == 5'b00000) begin
                cyc += 2;
                halted = 1'b1;
                break;
            end
            case (op)
                OpcLli:  begin r[rd] = {8'h00, ir[7:0]}; cyc += 4; end
                OpcLdr:  begin r[rd] = mm[a[7:0]]; cyc += 5; end
                OpcStr:  begin mm[a[7:0]] = r[rd]; cyc += 4; end
                OpcAddi: begin r[rd] = a; cyc += 4; end
                OpcSubi: begin r[rd] = r[rs] - {11'h0, ir[4:0]}; cyc += 4; end
                OpcBne: begin
                    if (r[rd] != 16'h0) pc = pc + {{8{ir[7]}}, ir[7:0]};
                    cyc += 3;
                end
                OpcOut:  begin exp_outs.push_back(r[rs]); cyc += 3; end
                default: cyc += 3;
            endcase
        end
    endtask

    // Resets the core, starts it, records OutR after every OUT execution
    task automatic run_dut(input int max_cyc, output int cyc, output bit done);
        logic [4:0]  prev_state;
        logic [15:0] prev_ir;
        got_outs.delete();
        test      = 1'b0;
        tMemWrite = 1'b0;
        rst_n     = 1'b0;
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        prev_state = state;
        prev_ir    = opcode;
        cyc  = 0;
        done = 1'b0;
        while (cyc < max_cyc && !done) begin
            tick();
            cyc++;
            if (prev_state == 5'd3 && prev_ir[15:11] == OpcOut) got_outs.push_back(OutR);
            prev_state = state;
            prev_ir    = opcode;
            if (state == 5'd6) done = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic compare_outs(input string tag);
        check({tag, "_out_count"}, 32'(got_outs.size()), 32'(exp_outs.size()));
        for (int i = 0; i < exp_outs.size() && i < got_outs.size(); i++) begin
            check($sformatf("%s_out%0d", tag, i), {16'h0, got_outs[i]}, {16'h0, exp_outs[i]});
        end
    endtask

    task automatic build_demo();
        logic [15:0] prog [20];
        prog = '{16'h1000, 16'hE000, 16'h1225, 16'hE040, 16'h1103, 16'hE020,
                 16'h1B43, 16'hE060, 16'h2B40, 16'h3801, 16'h3A41, 16'h4121, 16'hC1F9,
                 16'h1025, 16'h1103, 16'h1A00, 16'hE040, 16'h3801, 16'h4121, 16'hC1FB};
        for (int i = 0; i < 256; i++) img[i] = 16'h0;
        for (int i = 0; i < 20; i++) img[i] = prog[i];
        img[8'h28] = 16'd7;
        img[8'h29] = 16'd8;
        img[8'h2A] = 16'd9;
    endtask

    task automatic set_demo_outs();
        exp_outs.delete();
        exp_outs = '{16'h0000, 16'h0025, 16'h0003, 16'h0007, 16'h0008, 16'h0009,
                     16'h0007, 16'h0008, 16'h0009};
    endtask

    function automatic logic [15:0] rand_instr();
        logic [2:0]  rd, rs;
        logic [4:0]  imm5;
        logic [7:0]  imm8;
        rd   = 3'($urandom_range(0, 7));
        rs   = 3'($urandom_range(0, 7));
        imm5 = 5'($urandom_range(0, 31));
        imm8 = 8'($urandom_range(0, 255));
        case ($urandom_range(0, 8))
            0:       return {OpcLli, rd, imm8};
            1:       return {OpcLdr, rd, rs, imm5};
            2:       return {OpcStr, rd, rs, imm5};
            3:       return {OpcAddi, rd, rs, imm5};
            4:       return {OpcSubi, rd, rs, imm5};
            5:       return {OpcBne, rd, 8'($urandom_range(0, 3))};
            6, 7:    return {OpcOut, rd, rs, imm5};
            default: return {5'b11111, rd, imm8};
        endcase
    endfunction

    initial begin
        int          cyc, mcyc;
        bit          done, mh, ok;
        logic [15:0] rv;
        int          mism;

        rst_n = 1'b0; test = 1'b0; tMemWrite = 1'b0; TestMem = 1'b0; start = 1'b0;
        ext_addr = 16'h0; ext_data = 16'h0;
        #3;
        check("reset_state", {27'h0, state}, 32'd0);
        check("reset_outr", {16'h0, OutR}, 32'h0);
        check("reset_ir", {16'h0, opcode}, 32'h0);
        check("reset_testmemout", {16'h0, TestMemout}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Test-port vectors: optional write, then readback with TestMem
        vecs[0] = '{1'b1, 1'b1, 16'h0002, 16'h1025, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 1'b1, 16'h1025};
        vecs[2] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 16'h0305, 16'hBEEF, 1'b1, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b1, 16'hFF05, 16'h0000, 1'b1, 16'hBEEF};
        vecs[5] = '{1'b1, 1'b1, 16'h00FF, 16'hA5A5, 1'b1, 16'hA5A5};
        vecs[6] = '{1'b1, 1'b0, 16'h0002, 16'hDEAD, 1'b1, 16'h1025};
        vecs[7] = '{1'b0, 1'b1, 16'h0102, 16'h0000, 1'b1, 16'h1025};
        for (int i = 0; i < 8; i++) begin
            test     = vecs[i].tst;
            TestMem  = 1'b0;
            ext_addr = vecs[i].addr;
            ext_data = vecs[i].data;
            if (vecs[i].wr) begin
                tMemWrite = 1'b1;
                tick();
                tMemWrite = 1'b0;
            end
            TestMem = vecs[i].tmem;
            #1;
            check($sformatf("testport_vec%0d", i), {16'h0, TestMemout}, {16'h0, vecs[i].exp});
        end
        test = 1'b0;
        TestMem = 1'b0;
        tick();

        // Demo program
        build_demo();
        mm = img;
        model_run(mcyc, mh);
        load_img();
        run_dut(3000, cyc, done);
        check("demo_halted", {31'h0, done}, 32'd1);
        check("demo_cycles", 32'(cyc), 32'(mcyc));
        check("demo_state", {27'h0, state}, 32'd6);
        set_demo_outs();
        compare_outs("demo");
        for (int i = 0; i < 3; i++) begin
            mem_read(16'h0025 + 16'(i), rv);
            check($sformatf("demo_mem%0h", 16'h25 + i), {16'h0, rv}, 32'(7 + i));
        end
        TestMem = 1'b0;
        tick();

        // Reset mid-run: immediate clear, memory kept, clean restart
        rst_n = 1'b0; #2; rst_n = 1'b1; start = 1'b1;
        repeat (60) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_state", {27'h0, state}, 32'd0);
        check("midreset_outr", {16'h0, OutR}, 32'h0);
        check("midreset_ir", {16'h0, opcode}, 32'h0);
        start = 1'b0;
        mem_read(16'h0006, rv);
        check("midreset_prog_kept", {16'h0, rv}, 32'h1B43);
        mem_read(16'h0028, rv);
        check("midreset_data_kept", {16'h0, rv}, 32'h0007);
        TestMem = 1'b0;
        tick();
        rst_n = 1'b1;
        run_dut(3000, cyc, done);
        check("restart_halted", {31'h0, done}, 32'd1);
        set_demo_outs();
        compare_outs("restart");

        // Raise test during a run
        rst_n = 1'b0; #2; rst_n = 1'b1; start = 1'b1;
        repeat (20) tick();
        test = 1'b1;
        tick();
        check("test_forces_idle", {27'h0, state}, 32'd0);
        ext_addr = 16'h0030; ext_data = 16'h1234; tMemWrite = 1'b1;
        tick();
        tMemWrite = 1'b0;
        mem_read(16'h0030, rv);
        check("test_write_midrun", {16'h0, rv}, 32'h1234);
        TestMem = 1'b0;
        repeat (3) tick();
        check("idle_held_in_test", {27'h0, state}, 32'd0);
        test = 1'b0;
        tick();
        check("leave_test_fetch", {27'h0, state}, 32'd1);
        start = 1'b0;

        // Corner program: SUBI wrap, taken BNE, unknown op as NOP
        for (int i = 0; i < 256; i++) img[i] = 16'h0;
        img[0] = 16'h4121; img[1] = 16'hE020; img[2] = 16'hC101; img[3] = 16'hE000;
        img[4] = 16'h1055; img[5] = 16'hF800; img[6] = 16'hE000; img[7] = 16'h0000;
        tick();
        load_img();
        run_dut(500, cyc, done);
        check("corner_halted", {31'h0, done}, 32'd1);
        check("corner_cycles", 32'(cyc), 32'd23);
        exp_outs.delete();
        exp_outs = '{16'hFFFF, 16'h0055};
        compare_outs("corner");
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            mem_read(16'(i), rv);
            if (rv !== img[i]) mism++;
        end
        check("corner_mem_unchanged", 32'(mism), 32'd0);
        TestMem = 1'b0;
        tick();

        // Random programs against the ISA model
        for (int p = 0; p < 8; p++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                for (int i = 0; i < 256; i++) begin
                    if (i < 20)      img[i] = rand_instr();
                    else if (i < 32) img[i] = 16'h0000;
                    else             img[i] = 16'($urandom());
                end
                mm = img;
                model_run(mcyc, mh);
                ok = mh;
            end
            if (ok) begin
                load_img();
                run_dut(3000, cyc, done);
                check($sformatf("rand%0d_halted", p), {31'h0, done}, 32'd1);
                check($sformatf("rand%0d_cycles", p), 32'(cyc), 32'(mcyc));
                compare_outs($sformatf("rand%0d", p));
                mism = 0;
                for (int i = 0; i < 256; i++) begin
                    mem_read(16'(i), rv);
                    if (rv !== mm[i]) mism++;
                end
                check($sformatf("rand%0d_mem_mismatches", p), 32'(mism), 32'd0);
                TestMem = 1'b0;
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/risc16_cpu.md
# risc16_cpu

Multicycle 16-bit load/store processor with eight general registers, a unified 256×16 instruction/data memory, and an output register. An external test port loads and inspects memory while the core is idle. It is the top-level compute block of the FPGA RISC design, and `OutR` drives the board's display path.

## Interface
- No parameters. The memory depth is fixed at 256 words; only `ext_addr[7:0]` is decoded.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. Clears the core state only; memory contents are preserved.
- `ext_addr` in 16: test-port memory address.
- `ext_data` in 16: test-port write data.
- `test` in 1: 1 = test mode; the core is held in IDLE and the test port owns the memory.
- `tMemWrite` in 1: test-port write enable, qualified by `test`.
- `TestMem` in 1: enables the `TestMemout` readback.
- `start` in 1: run request. Level-sensitive; sampled in IDLE.
- `OutR` out 16: output register, written by OUT.
- `state` out 5: current FSM state code.
- `opcode` out 16: current instruction register (IR).
- `TestMemout` out 16: `mem[ext_addr]` when `TestMem`=1, else 0. Combinational.

## Operation
- Instruction fields:
  - `op`=[15:11]; `rd`=[10:8]; `rs`=[7:5]; `imm5`=[4:0], zero-extended; `imm8`=[7:0].
  - For BNE, `off8`=[7:0] is sign-extended.
- Instructions:
  - 00010 LLI: `R[rd]` <= {8'h00, imm8}.
  - 00011 LDR: `R[rd]` <= `mem[R[rs]+imm5]`.
  - 00101 STR: `mem[R[rs]+imm5]` <= `R[rd]`.
  - 00111 ADDI: `R[rd]` <= `R[rs]+imm5`.
  - 01000 SUBI: `R[rd]` <= `R[rs]-imm5`.
  - 11000 BNE: if `R[rd]` != 0, PC <= PC+1+sext(off8); otherwise PC+1.
  - 11100 OUT: `OutR` <= `R[rs]`.
  - 00000 HALT: stop.
  - Any other op executes as a NOP.
- Arithmetic is 16-bit and wraps modulo 2^16. Memory addresses use the low 8 bits.
- Test port, when `test`=1 and `tMemWrite`=1: `mem[ext_addr]` <= `ext_data` on each clk edge.
- Memory read is combinational and memory write is synchronous. When `test`=1 the core issues no memory writes.

## Timing
- FSM state codes:
  - IDLE=0
  - FETCH=1: IR <= `mem[PC]`, PC <= PC+1.
  - DECODE=2
  - EXEC=3: ALU operation; BNE PC update; OUT write.
  - MEM=4: LDR/STR only.
  - WB=5: register write.
  - HALT=6
- Transitions:
  - IDLE→FETCH when `start`=1 and `test`=0.
  - FETCH→DECODE→EXEC.
  - EXEC→MEM for LDR/STR; EXEC→WB for LLI/ADDI/SUBI; EXEC→FETCH for BNE/OUT/NOP.
  - MEM→WB for LDR; MEM→FETCH for STR.
  - WB→FETCH.
  - DECODE→HALT for op 00000.
  - HALT holds until reset.
- Instruction latency:
  - 3 cycles: BNE, OUT, NOP.
  - 4 cycles: LLI, ADDI, SUBI, STR.
  - 5 cycles: LDR.
- `test`=1 in any state forces IDLE on the next edge.
- Reset values: state=IDLE, PC=0, IR=0, `OutR`=0, R0–R7=0.
- Reset asserted mid-instruction aborts the instruction. A STR is lost only if reset arrives before its MEM edge.
- Register writes become visible to the next instruction's DECODE.
- PC is 16 bits; 0xFFFF+1 wraps to 0.

## Structure
- Shared package: opcode constants, state codes, and field-slice helpers.
- Natural sub-module: `risc16_regfile`, 8×16 registers with one write port and two combinational read ports, reset to 0.
- The memory array stays in the top level together with the test-port mux.

## Test plan
- Reset, then write 0x1025 to mem[2] via the test port with `test`=1 and `tMemWrite`=1. Read back with `TestMem`=1 and `ext_addr`=2 → `TestMemout`=0x1025; `TestMem`=0 → 0.
- Load the program below, pulse reset, set `test`=0 and `start`=1. `OutR` must take the sequence 0x0000, 0x0025, 0x0003, 0x0007, 0x0008, 0x0009, 0x0007, 0x0008, 0x0009. `state` must then equal 6, and mem[0x25..0x27] must read 7, 8, 9 via `TestMemout`.
  - 0x00–0x05: 0x1000, 0xE000, 0x1225, 0xE040, 0x1103, 0xE020.
  - 0x06–0x0C: 0x1B43, 0xE060, 0x2B40, 0x3801, 0x3A41, 0x4121, 0xC1F9.
  - 0x0D–0x13: 0x1025, 0x1103, 0x1A00, 0xE040, 0x3801, 0x4121, 0xC1FB.
  - Data: mem[0x28..0x2A] = 7, 8, 9.
- SUBI R1,R1,#1 with R1=0 → R1=0xFFFF, and BNE on R1 is then taken.
- Assert `rst_n` during a looping run → outputs and `state` are 0 immediately. Memory is unchanged; a restart re-executes from PC=0.
- With `start`=1, raise `test` mid-run → `state`=0 on the next cycle, and test-port writes take effect.
- Unknown op 0xF800 → executes as a NOP (3 cycles, no register or memory change), and the next instruction executes normally.
